// File: rtl/accel_mem_if.sv
// Memory-side front end of the hash accelerator: fetches one 512-bit message
// block through the data-memory arbiter, then writes the result words back.
module accel_mem_if #(
  parameter int unsigned RES_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_start,
  input  logic [15:0]  cmd_rd_addr,
  input  logic [15:0]  cmd_wr_addr,
  output logic         cmd_busy,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic [255:0] res_data,
  input  logic         res_valid,
  output logic         done,
  output logic [15:0]  accel_addr,
  output logic [31:0]  accel_wrt_data,
  output logic         accel_wrt_en,
  output logic         accel_rd_en,
  input  logic         accel_wrt_done,
  input  logic         accel_rd_valid,
  input  logic [511:0] accel_rd_data,
  output logic [15:0]  stall_cnt
);

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned RES_CAP   = 8;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RES_WORDS - 1);
  localparam logic [ADDR_W-1:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_WAIT_RES = 3'd3,
    S_WR_REQ   = 3'd4,
    S_WR_DRAIN = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [255:0]      r_res, w_res_nxt;
  logic [511:0]      r_blk, w_blk_nxt;
  logic [ADDR_W-1:0] r_stall, w_stall_nxt;
  logic              r_wr_first, w_wr_first_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_blk_valid, w_blk_valid_nxt;
  logic              w_stall_inc;

  // Result words past the 256-bit bus read as zero.
  function automatic logic [DATA_W-1:0] f_word(input logic [255:0] res,
                                               input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] word;
    word = '0;
    if (idx < IDX_W'(RES_CAP)) word = res[{idx[2:0], 5'b0} +: DATA_W];
    return word;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (cmd_start)      w_state_nxt = S_RD_REQ;
      S_RD_REQ:   if (accel_rd_valid) w_state_nxt = S_RD_DRAIN;
      S_RD_DRAIN:                     w_state_nxt = S_WAIT_RES;
      S_WAIT_RES: if (res_valid)      w_state_nxt = S_WR_REQ;
      S_WR_REQ:   if (accel_wrt_done) w_state_nxt = S_WR_DRAIN;
      S_WR_DRAIN: w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_WR_REQ;
      S_DONE:                         w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output, decoded from the upcoming state so
  // request lines line up with the cycles the FSM sits in a REQ state.
  always_comb begin
    w_rd_addr_nxt   = r_rd_addr;
    w_wr_addr_nxt   = r_wr_addr;
    w_idx_nxt       = r_idx;
    w_res_nxt       = r_res;
    w_blk_nxt       = r_blk;
    w_stall_nxt     = r_stall;
    w_stall_inc     = 1'b0;
    w_addr_nxt      = '0;
    w_wdata_nxt     = '0;
    w_rd_en_nxt     = 1'b0;
    w_wr_en_nxt     = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_blk_valid_nxt = (r_state == S_RD_DRAIN);
    // Write ack lags the grant by a cycle, so the first WR_REQ cycle never stalls.
    w_wr_first_nxt  = (w_state_nxt == S_WR_REQ) && (r_state != S_WR_REQ);

    case (r_state)
      S_IDLE: begin
        if (cmd_start) begin
          w_rd_addr_nxt = cmd_rd_addr;
          w_wr_addr_nxt = cmd_wr_addr;
          w_idx_nxt     = '0;
          w_stall_nxt   = '0;
        end
      end
      S_RD_REQ: begin
        if (accel_rd_valid) w_blk_nxt   = accel_rd_data;
        else                w_stall_inc = 1'b1;
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          w_res_nxt = res_data;
          w_idx_nxt = '0;
        end
      end
      S_WR_REQ: begin
        if (!accel_wrt_done && !r_wr_first) w_stall_inc = 1'b1;
      end
      S_WR_DRAIN: begin
        if (r_idx != LAST_IDX) w_idx_nxt = r_idx + IDX_W'(1);
      end
      default: ;
    endcase

    if (w_stall_inc && (r_stall != STALL_MAX)) w_stall_nxt = r_stall + ADDR_W'(1);

    if (w_state_nxt == S_RD_REQ) begin
      w_rd_en_nxt = 1'b1;
      w_addr_nxt  = w_rd_addr_nxt;
    end else if (w_state_nxt == S_WR_REQ) begin
      w_wr_en_nxt = 1'b1;
      w_addr_nxt  = w_wr_addr_nxt + ADDR_W'(w_idx_nxt);
      w_wdata_nxt = f_word(w_res_nxt, w_idx_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_idx       <= '0;
      r_res       <= '0;
      r_blk       <= '0;
      r_stall     <= '0;
      r_wr_first  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_blk_valid <= 1'b0;
    end else begin
      r_rd_addr   <= w_rd_addr_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_idx       <= w_idx_nxt;
      r_res       <= w_res_nxt;
      r_blk       <= w_blk_nxt;
      r_stall     <= w_stall_nxt;
      r_wr_first  <= w_wr_first_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_blk_valid <= w_blk_valid_nxt;
    end
  end

  assign cmd_busy       = r_busy;
  assign blk_data       = r_blk;
  assign blk_valid      = r_blk_valid;
  assign done           = r_done;
  assign accel_addr     = r_addr;
  assign accel_wrt_data = r_wdata;
  assign accel_wrt_en   = r_wr_en;
  assign accel_rd_en    = r_rd_en;
  assign stall_cnt      = r_stall;

endmodule

// File: tb/tb_accel_mem_if.sv
// Scoreboard bench for accel_mem_if: a behavioural arbiter answers requests,
// expected writes/blocks are queued at issue and checked by a monitor.
module tb_accel_mem_if;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_start;
  logic [15:0]  cmd_rd_addr;
  logic [15:0]  cmd_wr_addr;
  logic         cmd_busy;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic [255:0] res_data;
  logic         res_valid;
  logic         done;
  logic [15:0]  accel_addr;
  logic [31:0]  accel_wrt_data;
  logic         accel_wrt_en;
  logic         accel_rd_en;
  logic         accel_wrt_done;
  logic         accel_rd_valid;
  logic [511:0] accel_rd_data;
  logic [15:0]  stall_cnt;

  accel_mem_if #(.RES_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_rd_addr(cmd_rd_addr), .cmd_wr_addr(cmd_wr_addr),
    .cmd_busy(cmd_busy), .blk_data(blk_data), .blk_valid(blk_valid),
    .res_data(res_data), .res_valid(res_valid), .done(done),
    .accel_addr(accel_addr), .accel_wrt_data(accel_wrt_data),
    .accel_wrt_en(accel_wrt_en), .accel_rd_en(accel_rd_en),
    .accel_wrt_done(accel_wrt_done), .accel_rd_valid(accel_rd_valid),
    .accel_rd_data(accel_rd_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [511:0] data; int cyc; } blk_t;

  wr_t  q_wr[$];
  blk_t q_blk[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done = 0;
  int last_wdone_cyc = -100;

  // Arbiter knobs set by the stimulus
  logic [511:0] mem_blk = '0;
  int rd_hold = 0;
  bit rd_dup = 1'b0;
  bit dup_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural arbiter: read ack after rd_hold stalled cycles, write ack one
  // cycle after grant; optional duplicate read/write acks.
  initial begin
    int  rd_cnt;
    int  wr_cnt;
    bit  wr_granted;
    bit  rd_prev;
    int  dup_phase;
    rd_cnt = 0; wr_cnt = 0; wr_granted = 0; rd_prev = 0; dup_phase = 0;
    accel_rd_valid = 1'b0;
    accel_rd_data  = '0;
    accel_wrt_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (accel_rd_en && rd_cnt >= rd_hold) begin
        accel_rd_valid = 1'b1;
        accel_rd_data  = mem_blk;
      end else if (rd_dup && rd_prev) begin
        accel_rd_valid = 1'b1;
        accel_rd_data  = ~mem_blk;
      end else begin
        accel_rd_valid = 1'b0;
        accel_rd_data  = ~mem_blk;
      end
      rd_prev = accel_rd_en && accel_rd_valid;
      rd_cnt  = accel_rd_en ? rd_cnt + 1 : 0;

      if (dup_phase == 1) begin
        accel_wrt_done = 1'b1;
        dup_phase = 2;
      end else if (dup_phase == 2) begin
        accel_wrt_done = 1'b1;
        dup_phase = 0;
      end else begin
        accel_wrt_done = wr_granted;
      end
      if (dup_arm && accel_wrt_done && accel_wrt_en && dup_phase == 0) begin
        dup_phase = 1;
        dup_arm   = 1'b0;
      end
      wr_granted = accel_wrt_en && (wr_cnt == 0) && !accel_wrt_done;
      wr_cnt     = accel_wrt_en ? wr_cnt + 1 : 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((accel_rd_en && accel_wrt_en) ||
          (!accel_rd_en && !accel_wrt_en && (accel_addr != 16'h0 || accel_wrt_data != 32'h0))) begin
        failures++;
        $display("FAIL bus_idle cyc=%0d rd_en=%b wr_en=%b addr=%h wdata=%h, required exclusive enables and zero idle bus",
                 cyc, accel_rd_en, accel_wrt_en, accel_addr, accel_wrt_data);
      end
      if (accel_wrt_en && accel_wrt_done) begin
        checks++;
        if (q_wr.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected cyc=%0d addr=%h data=%h, required no write", cyc, accel_addr, accel_wrt_data);
        end else begin
          wr_t e;
          e = q_wr.pop_front();
          if (accel_addr != e.addr || accel_wrt_data != e.data) begin
            failures++;
            $display("FAIL write cyc=%0d addr=%h data=%h, required addr=%h data=%h",
                     cyc, accel_addr, accel_wrt_data, e.addr, e.data);
          end
        end
        last_wdone_cyc = cyc;
      end
      if (blk_valid) begin
        checks++;
        if (q_blk.size() == 0) begin
          failures++;
          $display("FAIL blk_unexpected cyc=%0d", cyc);
        end else begin
          blk_t b;
          b = q_blk.pop_front();
          if (blk_data != b.data || cyc != b.cyc) begin
            failures++;
            $display("FAIL blk cyc=%0d data=%h, required cyc=%0d data=%h", cyc, blk_data, b.cyc, b.data);
          end
        end
      end
      if (done) begin
        checks++;
        n_done++;
        if (cyc != last_wdone_cyc + 2 || q_wr.size() != 0) begin
          failures++;
          $display("FAIL done cyc=%0d pending_writes=%0d, required cyc=%0d pending_writes=0",
                   cyc, q_wr.size(), last_wdone_cyc + 2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setup_cmd(input logic [15:0] rd, input logic [15:0] wr, input int tag,
                           input int hold, output logic [255:0] res, output int t0);
    logic [511:0] blk;
    for (int j = 0; j < 16; j++) blk[32*j +: 32] = 32'hB000_0000 + 32'(tag << 16) + 32'(j);
    for (int i = 0; i < 8; i++)  res[32*i +: 32] = 32'hA000_0000 + 32'(tag << 8) + 32'(i);
    mem_blk = blk;
    rd_hold = hold;
    for (int i = 0; i < 8; i++) q_wr.push_back('{wr + 16'(i), res[32*i +: 32]});
    tick();
    cmd_rd_addr = rd;
    cmd_wr_addr = wr;
    cmd_start   = 1'b1;
    t0 = cyc;
    q_blk.push_back('{blk, t0 + 3 + hold});
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic send_res(input logic [255:0] res, input int t0, input int res_at);
    while (cyc < t0 + res_at) tick();
    res_valid = 1'b1;
    res_data  = res;
    tick();
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  task automatic run_cmd(input logic [15:0] rd, input logic [15:0] wr, input int tag,
                         input int hold, input bit dup_rd, input int res_at,
                         input bit res_early, input bit start_in_wr, input bit dup_wr,
                         input logic [15:0] exp_stall);
    logic [255:0] res;
    int t0;
    int exp_done;
    exp_done = n_done + 1;
    rd_dup   = dup_rd;
    dup_arm  = dup_wr;
    setup_cmd(rd, wr, tag, hold, res, t0);
    if (res_early) begin
      res_valid = 1'b1;
      res_data  = ~res;
      tick();
      res_valid = 1'b0;
      res_data  = '0;
    end
    send_res(res, t0, res_at);
    if (start_in_wr) begin
      for (int k = 0; k < 20 && !accel_wrt_en; k++) tick();
      cmd_start   = 1'b1;
      cmd_rd_addr = 16'hDEAD;
      cmd_wr_addr = 16'hBEEF;
      tick();
      cmd_start = 1'b0;
    end
    for (int k = 0; k < 200 && n_done < exp_done; k++) tick();
    checks++;
    if (n_done != exp_done) begin
      failures++;
      $display("FAIL done_timeout tag=%0d done_count=%0d, required %0d", tag, n_done, exp_done);
    end
    checks++;
    if (stall_cnt != exp_stall || cmd_busy != 1'b0 || q_blk.size() != 0) begin
      failures++;
      $display("FAIL end_state tag=%0d stall=%0d busy=%b blk_pending=%0d, required stall=%0d busy=0 blk_pending=0",
               tag, stall_cnt, cmd_busy, q_blk.size(), exp_stall);
    end
    rd_dup  = 1'b0;
    dup_arm = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] res;
    int t0;
    bit hit;
    bit quiet;
    cmd_start = 1'b0; cmd_rd_addr = '0; cmd_wr_addr = '0;
    res_valid = 1'b0; res_data = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cmd_busy, blk_valid, done, accel_wrt_en, accel_rd_en} != 5'b0 || blk_data != '0 ||
        accel_addr != 16'h0 || accel_wrt_data != 32'h0 || stall_cnt != 16'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b addr=%h wdata=%h stall=%h, required all zero",
               cmd_busy, accel_addr, accel_wrt_data, stall_cnt);
    end
    rst_n = 1'b1;
    tick();

    run_cmd(16'h0100, 16'h0200, 1, 0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 16'd0);
    run_cmd(16'h0140, 16'h0300, 2, 5, 1'b1, 14, 1'b1, 1'b0, 1'b0, 16'd5);
    run_cmd(16'h0180, 16'h0400, 3, 0, 1'b0, 8,  1'b0, 1'b0, 1'b1, 16'd0);
    run_cmd(16'h01C0, 16'hFFFC, 4, 0, 1'b0, 8,  1'b0, 1'b1, 1'b0, 16'd0);

    // Abort a command while word 3 is being requested.
    setup_cmd(16'h0500, 16'h0600, 5, 0, res, t0);
    send_res(res, t0, 10);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      if (accel_wrt_en && accel_addr == 16'h0603) hit = 1'b1;
      else tick();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL word3_timeout addr=%h, required 0603", accel_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_busy, blk_valid, done, accel_wrt_en, accel_rd_en} != 5'b0 || blk_data != '0 ||
        accel_addr != 16'h0 || accel_wrt_data != 32'h0 || stall_cnt != 16'h0) begin
      failures++;
      $display("FAIL midcmd_reset busy=%b wr_en=%b addr=%h wdata=%h, required all zero",
               cmd_busy, accel_wrt_en, accel_addr, accel_wrt_data);
    end
    q_wr.delete();
    q_blk.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (cmd_busy || accel_rd_en || accel_wrt_en) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL post_reset_quiet busy=%b rd_en=%b wr_en=%b, required no activity",
               cmd_busy, accel_rd_en, accel_wrt_en);
    end

    run_cmd(16'h0700, 16'h0800, 6, 0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 16'd0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
